data_mem_wbuf: RTL and testbench

DATA_MEM_WBUF -- requirements
Module: data_mem_wbuf

---
 rtl/data_mem_wbuf.sv | 172 +++++++++++++++++
 tb/tb_data_mem_wbuf.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_wbuf.sv
// Data-memory front end with a DEPTH-entry posted write buffer draining to a single-port RAM.
// Define WBUF_FORWARD_EN to enable store-to-load forwarding and load bypass of pending drains.
module data_mem_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in [0:3],
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [7:0]  mem_data_out [0:3],
    output logic        stall,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RDONE = 2'd3} state_t;

    state_t         state_r, state_s;
    logic [29:0]    buf_addr_r [DEPTH];
    logic [31:0]    buf_data_r [DEPTH];
    logic [PW-1:0]  head_r, tail_r;
    logic [PW:0]    count_r;
    logic [31:0]    rdata_r;

    logic [31:0]    wr_word_s, out_word_s, fwd_data_s;
    logic           is_store_s, is_load_s, full_s, drain_s, enq_s, deq_s;
    logic           hit_s, cover_s, can_read_s;
    logic           unused_s;

    assign unused_s   = ^mem_addr[1:0];
    assign wr_word_s  = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
    assign is_store_s = mem_write_en;
    assign is_load_s  = mem_read_en & ~mem_write_en;
    assign full_s     = (count_r == (PW+1)'(DEPTH));
    assign drain_s    = (state_r == WR) & ram_ready;
    // A full buffer still accepts a store on the edge that retires the head entry.
    assign enq_s      = is_store_s & (~full_s | drain_s);
    assign deq_s      = drain_s;
    assign cover_s    = is_load_s & hit_s;

`ifdef WBUF_FORWARD_EN
    logic [PW-1:0] fwd_idx_s;

    // Scan oldest to newest so the youngest matching entry wins.
    always_comb begin
        hit_s      = 1'b0;
        fwd_data_s = 32'd0;
        fwd_idx_s  = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_r + PW'(i);
            if (((PW+1)'(i) < count_r) && (buf_addr_r[fwd_idx_s] == mem_addr[31:2])) begin
                hit_s      = 1'b1;
                fwd_data_s = buf_data_r[fwd_idx_s];
            end else begin
                hit_s      = hit_s;
            end
        end
    end
    assign can_read_s = 1'b1;
`else
    assign hit_s      = 1'b0;
    assign fwd_data_s = 32'd0;
    assign can_read_s = (count_r == '0);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state selection; uncovered loads take priority over draining when allowed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (is_load_s && !cover_s && can_read_s)  state_s = RD;
                else if ((count_r != '0) || enq_s)        state_s = WR;
                else                                      state_s = IDLE;
            end
            WR: begin
                if (ram_ready) state_s = IDLE;
                else           state_s = WR;
            end
            RD: begin
                if (ram_ready) state_s = RDONE;
                else           state_s = RD;
            end
            RDONE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // RAM request, core stall and load data; all forced low while reset is held.
    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = 32'd0;
        ram_wdata  = 32'd0;
        stall      = 1'b0;
        out_word_s = 32'd0;
        if (rst_b) begin
            case (state_r)
                WR: begin
                    ram_we    = 1'b1;
                    ram_addr  = {buf_addr_r[head_r], 2'b00};
                    ram_wdata = buf_data_r[head_r];
                end
                RD: begin
                    ram_re   = 1'b1;
                    ram_addr = {mem_addr[31:2], 2'b00};
                end
                default: ram_we = 1'b0;
            endcase
            if (state_r == RDONE) out_word_s = rdata_r;
            else if (cover_s)     out_word_s = fwd_data_s;
            else                  out_word_s = 32'd0;
            if (is_store_s)     stall = ~enq_s;
            else if (is_load_s) stall = ~(cover_s | (state_r == RDONE));
            else                stall = 1'b0;
        end else begin
            stall = 1'b0;
        end
    end

    // Big-endian byte lanes toward the core.
    always_comb begin
        mem_data_out[0] = out_word_s[31:24];
        mem_data_out[1] = out_word_s[23:16];
        mem_data_out[2] = out_word_s[15:8];
        mem_data_out[3] = out_word_s[7:0];
    end

    // Buffer payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            buf_addr_r[tail_r] <= mem_addr[31:2];
            buf_data_r[tail_r] <= wr_word_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq_s) tail_r <= tail_r + PW'(1'b1);
            if (deq_s) head_r <= head_r + PW'(1'b1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Load result register, presented during RDONE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                          rdata_r <= 32'd0;
        else if ((state_r == RD) && ram_ready) rdata_r <= ram_rdata;
        else                                 rdata_r <= rdata_r;
    end
endmodule

// File: tb/tb_data_mem_wbuf.sv
// Scoreboard bench for data_mem_wbuf: a word-addressed coherent memory model predicts every
// RAM write (in issue order) and every load result; a negedge monitor pops and compares.
module tb_data_mem_wbuf;
    logic        clk, rst_b;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic        mem_write_en, mem_read_en;
    logic [7:0]  mem_data_out [0:3];
    logic        stall;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, ram_re, ram_ready;

    data_mem_wbuf #(.DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_data_out(mem_data_out),
        .stall(stall), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_re(ram_re), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    int n_chk = 0, n_pass = 0;
    int overlap = 0, re_cnt = 0;
    logic [31:0] exp_wa[$], exp_wd[$], exp_rd[$];
    int ev_log[$];
    logic [31:0] ref_mem [1024];
    logic [31:0] cmt_mem [1024];
    bit   [31:0] ram_mem [1024];
    bit          ram_vld [1024];
    logic rdy_en = 1'b1, rdy_force = 1'b0;
    int   lat = 0, wait_cnt = 0;

    function automatic logic [31:0] init_word(input logic [9:0] i);
        return (i == 10'h0C0) ? 32'hCAFEF00D : ({22'd0, i} ^ 32'hA5A50000);
    endfunction

    function automatic logic [31:0] out_word();
        return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    // RAM model: ready after lat cycles of a held request, or forced.
    assign ram_ready = rdy_force | (rdy_en & (ram_we | ram_re) & (wait_cnt >= lat));
    assign ram_rdata = ram_vld[ram_addr[11:2]] ? ram_mem[ram_addr[11:2]] : init_word(ram_addr[11:2]);
    initial forever begin
        @(posedge clk);
        if (ram_ready || !(ram_we || ram_re)) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (rst_b && ram_we && ram_ready) begin
            ram_mem[ram_addr[11:2]] <= ram_wdata;
            ram_vld[ram_addr[11:2]] <= 1'b1;
        end
    end

    // Monitor: compares completed RAM writes and presented load data against the scoreboard.
    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < 1024; i++) cmt_mem[i] = init_word(10'(i));
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (ram_we && ram_re) overlap++;
                if (ram_re) re_cnt++;
                if (ram_we && ram_ready) begin
                    if (exp_wa.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_write: got addr %h expected no write", ram_addr);
                    end else begin
                        a = exp_wa.pop_front(); d = exp_wd.pop_front();
                        chk("wr_addr", ram_addr, a);
                        chk("wr_data", ram_wdata, d);
                        cmt_mem[a[11:2]] = d;
                        ev_log.push_back(1);
                    end
                end
                if (ram_re && ram_ready) ev_log.push_back(2);
                if (mem_read_en && !mem_write_en && !stall) begin
                    if (exp_rd.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_load: got %h expected no load", out_word());
                    end else chk("load_data", out_word(), exp_rd.pop_front());
                end
            end
        end
    end

    task automatic drive_data(input logic [31:0] d);
        mem_data_in[0] = d[31:24]; mem_data_in[1] = d[23:16];
        mem_data_in[2] = d[15:8];  mem_data_in[3] = d[7:0];
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rd,
                            output logic st0, output int cyc);
        exp_wa.push_back({a[31:2], 2'b00}); exp_wd.push_back(d);
        ref_mem[a[11:2]] = d;
        mem_addr = a; drive_data(d); mem_write_en = 1'b1; mem_read_en = rd;
        @(negedge clk); st0 = stall; cyc = 0;
        while (stall && cyc < 100) begin @(negedge clk); cyc++; end
        if (stall) chk("store_timeout", 32'(stall), 32'd0);
        @(posedge clk); #1 mem_write_en = 1'b0; mem_read_en = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic st0, output logic [31:0] dat,
                           output logic re_end);
        int n;
        exp_rd.push_back(ref_mem[a[11:2]]);
        mem_addr = a; mem_read_en = 1'b1;
        @(negedge clk); st0 = stall; n = 0;
        while (stall && n < 100) begin @(negedge clk); n++; end
        dat = out_word(); re_end = ram_re;
        if (stall) begin chk("load_timeout", 32'(stall), 32'd0); void'(exp_rd.pop_front()); end
        @(posedge clk); #1 mem_read_en = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((exp_wa.size() != 0 || ram_we || ram_re) && n < 300) begin @(negedge clk); n++; end
        chk("drain_done", 32'(exp_wa.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic st; int cyc; logic [31:0] dat; logic re_e; int re0;
        int unsigned w, r;
        logic [31:0] a, d;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
        rst_b = 1'b0; mem_addr = 32'd0; drive_data(32'd0);
        mem_write_en = 1'b0; mem_read_en = 1'b0;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_re", 32'(ram_re), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_data_out", out_word(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        // Single zero-cycle store drains one cycle later.
        do_store(32'h100, 32'hDEADBEEF, 1'b0, st, cyc);
        chk("t1_store_stall", 32'(st), 32'd0);
        @(negedge clk);
        chk("t1_ram_we", 32'(ram_we), 32'd1);
        chk("t1_ram_addr", ram_addr, 32'h100);
        chk("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_idle_after", 32'(ram_we), 32'd0);
        @(posedge clk); #1;

        // Fill the buffer with RAM stalled; fifth store waits for the drain edge.
        rdy_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h500 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0, st, cyc);
            chk("t2_store_nostall", 32'(st), 32'd0);
        end
        fork begin @(posedge clk); @(posedge clk); #2 rdy_en = 1'b1; end join_none
        do_store(32'h510, 32'h1004, 1'b0, st, cyc);
        chk("t2_full_stall", 32'(st), 32'd1);
        chk("t2_full_released", 32'(cyc > 0), 32'd1);
        wait_quiet();

`ifdef WBUF_FORWARD_EN
        // Newest buffered store is forwarded without touching RAM.
        rdy_en = 1'b0; re0 = re_cnt;
        do_store(32'h200, 32'h11111111, 1'b0, st, cyc);
        do_store(32'h200, 32'h22222222, 1'b0, st, cyc);
        do_load(32'h200, st, dat, re_e);
        chk("t3_fwd_stall", 32'(st), 32'd0);
        chk("t3_fwd_data", dat, 32'h22222222);
        chk("t3_no_ram_re", 32'(re_cnt - re0), 32'd0);
        rdy_en = 1'b1;
        wait_quiet();
`else
        // Load waits behind both pending stores, then reads with 2-cycle latency.
        lat = 2; ev_log.delete();
        do_store(32'h310, 32'h00000001, 1'b0, st, cyc);
        do_store(32'h314, 32'h00000002, 1'b0, st, cyc);
        do_load(32'h300, st, dat, re_e);
        chk("t3_load_stalled", 32'(st), 32'd1);
        chk("t3_rdone_data", dat, 32'hCAFEF00D);
        chk("t3_rdone_no_re", 32'(re_e), 32'd0);
        wait_quiet();
        chk("t3_event_count", 32'(ev_log.size()), 32'd3);
        if (ev_log.size() == 3) begin
            chk("t3_ev0_write", 32'(ev_log[0]), 32'd1);
            chk("t3_ev1_write", 32'(ev_log[1]), 32'd1);
            chk("t3_ev2_read", 32'(ev_log[2]), 32'd2);
        end
        lat = 0;
`endif

        // Store and load together act as a store only.
        re0 = re_cnt;
        exp_wa.push_back(32'h40); exp_wd.push_back(32'h0BADC0DE); ref_mem[10'h10] = 32'h0BADC0DE;
        mem_addr = 32'h40; drive_data(32'h0BADC0DE); mem_write_en = 1'b1; mem_read_en = 1'b1;
        @(negedge clk);
        chk("t4_both_stall", 32'(stall), 32'd0);
        chk("t4_both_no_re", 32'(ram_re), 32'd0);
        @(posedge clk); #1 mem_write_en = 1'b0; mem_read_en = 1'b0;
        wait_quiet();
        chk("t4_re_never", 32'(re_cnt - re0), 32'd0);

        // Reset during a drain with three buffered entries discards them.
        rdy_en = 1'b0;
        for (int i = 0; i < 3; i++) do_store(32'h080 + 32'(i * 4), $urandom, 1'b0, st, cyc);
        @(negedge clk);
        chk("t5_we_before", 32'(ram_we), 32'd1);
        @(posedge clk); #1 rst_b = 1'b0;
        #1;
        chk("t5_we_dropped", 32'(ram_we), 32'd0);
        chk("t5_addr_cleared", ram_addr, 32'd0);
        exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < 1024; i++) ref_mem[i] = cmt_mem[i];
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1 rdy_force = 1'b1;
        @(posedge clk); #1 rdy_force = 1'b0;
        @(negedge clk);
        chk("t5_idle_we", 32'(ram_we), 32'd0);
        chk("t5_idle_re", 32'(ram_re), 32'd0);
        rdy_en = 1'b1;
        do_load(32'h084, st, dat, re_e);
        chk("t5_discarded", dat, init_word(10'h021));

        // Reset during RD drops the read request and stall at once.
        rdy_en = 1'b0; mem_addr = 32'h0C4; mem_read_en = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t6_re_before", 32'(ram_re), 32'd1);
        chk("t6_stall_before", 32'(stall), 32'd1);
        @(posedge clk); #1 rst_b = 1'b0;
        #1;
        chk("t6_re_dropped", 32'(ram_re), 32'd0);
        chk("t6_stall_dropped", 32'(stall), 32'd0);
        chk("t6_out_zero", out_word(), 32'd0);
        mem_read_en = 1'b0; rdy_en = 1'b1;
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1;

        // Randomized mix of stores, loads and combined requests.
        for (int k = 0; k < 80; k++) begin
            lat = int'($urandom_range(0, 3));
            w = $urandom_range(0, 15); r = $urandom_range(0, 9);
            a = 32'(w << 2) + 32'($urandom_range(0, 3));
            d = $urandom;
            if (r < 5)      do_store(a, d, 1'b0, st, cyc);
            else if (r < 9) do_load(a, st, dat, re_e);
            else            do_store(a, d, 1'b1, st, cyc);
        end
        wait_quiet();
        chk("no_we_re_overlap", 32'(overlap), 32'd0);
        chk("load_queue_empty", 32'(exp_rd.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
